// File: rtl/muldiv_unit_pkg.sv
// Shared CPU package: operation classes, multiply/divide opcodes and FSM states.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        OP_ALU,
        OP_SHIFT,
        OP_MULDIV,
        OP_LOAD,
        OP_STORE,
        OP_BRANCH
    } oper_t;

    typedef enum logic [3:0] {
        MD_NONE,
        MULT,
        MULTU,
        MADD,
        MADDU,
        MSUB,
        MSUBU,
        DIV,
        DIVU,
        MTHI,
        MTLO
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } muldiv_state_t;

    localparam int MUL_LATENCY_DEF = 2;
    localparam int DIV_BITS_DEF    = 1;

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Iterative restoring divider on magnitudes, DIV_BITS quotient bits per cycle,
// followed by one sign-fix cycle in which done is high.
module div_iter
    import muldiv_unit_pkg::*;
#(
    parameter int W        = 32,
    parameter int DIV_BITS = DIV_BITS_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         is_signed,
    output logic         done,
    output logic [W-1:0] quo,
    output logic [W-1:0] rem
);

    localparam int STEPS = W / DIV_BITS;
    localparam int CW    = $clog2(STEPS + 1);

    logic [W-1:0]  dq_q, rem_q, b_q;
    logic [W-1:0]  dq_n, rem_n;
    logic [W:0]    t;
    logic [CW-1:0] cnt_q;
    logic          run_q, fix_q, qneg_q, rneg_q;
    logic          a_neg, b_neg;

    assign a_neg = is_signed & a[W-1];
    assign b_neg = is_signed & b[W-1];

    always_comb begin
        rem_n = rem_q;
        dq_n  = dq_q;
        t     = '0;
        for (int i = 0; i < DIV_BITS; i++) begin
            t    = {rem_n, dq_n[W-1]};
            dq_n = {dq_n[W-2:0], 1'b0};
            if (t >= {1'b0, b_q}) begin
                t       = t - {1'b0, b_q};
                dq_n[0] = 1'b1;
            end
            rem_n = t[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dq_q   <= '0;
            rem_q  <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            fix_q  <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else if (start) begin
            dq_q   <= a_neg ? -a : a;
            b_q    <= b_neg ? -b : b;
            rem_q  <= '0;
            cnt_q  <= CW'(STEPS);
            run_q  <= 1'b1;
            fix_q  <= 1'b0;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
        end else if (run_q) begin
            dq_q  <= dq_n;
            rem_q <= rem_n;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_q <= 1'b0;
                fix_q <= 1'b1;
            end
        end else begin
            fix_q <= 1'b0;
        end
    end

    assign done = fix_q;
    assign quo  = qneg_q ? -dq_q : dq_q;
    assign rem  = rneg_q ? -rem_q : rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply-divide unit: pipelined multiplier, iterative divider and
// MTHI/MTLO bypass behind an IDLE/MUL/DIV/DONE handshake FSM.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int DIV_BITS    = DIV_BITS_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  muldiv_op_t              req_op,
    input  logic [DATA_WIDTH-1:0]   req_a,
    input  logic [DATA_WIDTH-1:0]   req_b,
    input  logic [2*DATA_WIDTH-1:0] hilo_i,
    input  logic                    flush,
    input  logic                    ack,
    output logic                    ready_o,
    output logic                    resp_valid,
    output logic [2*DATA_WIDTH-1:0] resp_hilo,
    output logic                    busy
);

    localparam int W = DATA_WIDTH;

    muldiv_state_t state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [2*W-1:0] res_q, res_d, hilo_q;
    logic [2*W-1:0] ext_a, ext_b, prod, mul_comb, mul_out;
    logic [W-1:0]  a_q, b_q, div_quo, div_rem;
    muldiv_op_t    op_q;
    logic          is_mul, is_div, is_mt, b_zero, mul_sgn;
    logic          mul_start, div_start, div_done, res_load;

    assign is_mul = req_op inside {MULT, MULTU, MADD, MADDU, MSUB, MSUBU};
    assign is_div = req_op inside {DIV, DIVU};
    assign is_mt  = req_op inside {MTHI, MTLO};
    assign b_zero = (req_b == '0);

    // Operands are sign- or zero-extended so one 2W multiply covers both forms.
    assign mul_sgn  = op_q inside {MULT, MADD, MSUB};
    assign ext_a    = {{W{mul_sgn & a_q[W-1]}}, a_q};
    assign ext_b    = {{W{mul_sgn & b_q[W-1]}}, b_q};
    assign prod     = ext_a * ext_b;

    always_comb begin
        unique case (op_q)
            MADD, MADDU: mul_comb = hilo_q + prod;
            MSUB, MSUBU: mul_comb = hilo_q - prod;
            default:     mul_comb = prod;
        endcase
    end

    // Capture and result registers already give two stages; extra ones go here.
    if (MUL_LATENCY > 2) begin : g_pipe
        logic [2*W-1:0] pipe_q [MUL_LATENCY-2];
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int k = 0; k < MUL_LATENCY - 2; k++)
                    pipe_q[k] <= '0;
            end else begin
                pipe_q[0] <= mul_comb;
                for (int k = 1; k < MUL_LATENCY - 2; k++)
                    pipe_q[k] <= pipe_q[k-1];
            end
        end
        assign mul_out = pipe_q[MUL_LATENCY-3];
    end else begin : g_nopipe
        assign mul_out = mul_comb;
    end

    div_iter #(
        .W        (W),
        .DIV_BITS (DIV_BITS)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .a         (req_a),
        .b         (req_b),
        .is_signed (req_op == DIV),
        .done      (div_done),
        .quo       (div_quo),
        .rem       (div_rem)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        res_d      = res_q;
        res_load   = 1'b0;
        mul_start  = 1'b0;
        div_start  = 1'b0;
        ready_o    = 1'b1;
        resp_valid = 1'b0;
        resp_hilo  = res_q;
        busy       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    unique case (1'b1)
                        is_mul: begin
                            ready_o   = 1'b0;
                            mul_start = 1'b1;
                            cnt_d     = 3'(MUL_LATENCY - 1);
                            state_d   = ST_MUL;
                        end
                        is_div && b_zero: begin
                            ready_o  = 1'b0;
                            res_d    = {req_a, {W{1'b1}}};
                            res_load = 1'b1;
                            state_d  = ST_DONE;
                        end
                        is_div && !b_zero: begin
                            ready_o   = 1'b0;
                            div_start = 1'b1;
                            state_d   = ST_DIV;
                        end
                        is_mt: begin
                            resp_valid = 1'b1;
                            resp_hilo  = (req_op == MTHI)
                                       ? {req_a, hilo_i[W-1:0]}
                                       : {hilo_i[2*W-1:W], req_a};
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                busy    = 1'b1;
                ready_o = 1'b0;
                cnt_d   = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    res_d    = mul_out;
                    res_load = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DIV: begin
                busy    = 1'b1;
                ready_o = 1'b0;
                if (div_done) begin
                    res_d    = {div_rem, div_quo};
                    res_load = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                if (ack)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d    = ST_IDLE;
            resp_valid = 1'b0;
            mul_start  = 1'b0;
            div_start  = 1'b0;
            res_load   = 1'b0;
        end
        // Outputs track reset immediately, even with a request on the inputs.
        if (!rst) begin
            ready_o    = 1'b1;
            resp_valid = 1'b0;
            resp_hilo  = '0;
            busy       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hilo_q  <= '0;
            op_q    <= MD_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (res_load)
                res_q <= res_d;
            if (mul_start) begin
                a_q    <= req_a;
                b_q    <= req_b;
                hilo_q <= hilo_i;
                op_q   <= req_op;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit; a second instance runs the 2-bit divider.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst, req_valid, flush, ack;
    muldiv_op_t  req_op;
    logic [31:0] req_a, req_b;
    logic [63:0] hilo_i;
    logic        ready_o, resp_valid, busy;
    logic [63:0] resp_hilo;
    logic        ready2, rv2, busy2;
    logic [63:0] hilo2;

    int n_cmp = 0;
    int n_err = 0;
    int lat, n1, n2, k, seen;
    logic [63:0] exp_q [$];
    muldiv_op_t  ops [8] = '{MULT, MULTU, MADD, MADDU, MSUB, MSUBU, DIV, DIVU};

    always #5 clk = ~clk;

    muldiv_unit #(
        .DATA_WIDTH (32),
        .MUL_LATENCY(2),
        .DIV_BITS   (1)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .hilo_i    (hilo_i),
        .flush     (flush),
        .ack       (ack),
        .ready_o   (ready_o),
        .resp_valid(resp_valid),
        .resp_hilo (resp_hilo),
        .busy      (busy)
    );

    muldiv_unit #(
        .DATA_WIDTH (32),
        .MUL_LATENCY(2),
        .DIV_BITS   (2)
    ) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .hilo_i    (hilo_i),
        .flush     (flush),
        .ack       (ack),
        .ready_o   (ready2),
        .resp_valid(rv2),
        .resp_hilo (hilo2),
        .busy      (busy2)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input muldiv_op_t op,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [63:0] h);
        logic [63:0] sp, up;
        int          sa, sb;
        logic [31:0] q, r;
        sp = 64'(longint'($signed(a)) * longint'($signed(b)));
        up = {32'b0, a} * {32'b0, b};
        sa = a;
        sb = b;
        q  = '0;
        r  = '0;
        case (op)
            MULT:  return sp;
            MULTU: return up;
            MADD:  return h + sp;
            MADDU: return h + up;
            MSUB:  return h - sp;
            MSUBU: return h - up;
            DIV: begin
                if (b == 0) return {a, 32'hffffffff};
                if (a == 32'h80000000 && b == 32'hffffffff)
                    return {32'h0, 32'h80000000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            DIVU: begin
                if (b == 0) return {a, 32'hffffffff};
                return {a % b, a / b};
            end
            MTHI:  return {a, h[31:0]};
            MTLO:  return {h[63:32], a};
            default: return '0;
        endcase
    endfunction

    // Entered and left at posedge+1; lat counts cycles from the start cycle.
    task automatic run_op(input string tag, input muldiv_op_t op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] h, input int hold,
                          output int olat, output int on1, output int on2);
        logic [63:0] e, obs, obs2;
        bit          got, got2;
        exp_q.push_back(model(op, a, b, h));
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        hilo_i    = h;
        olat = 0; on1 = 0; on2 = 0;
        got = 0; got2 = 0; obs = '0; obs2 = '0;
        while (!got && olat < 200) begin
            @(negedge clk);
            if (busy) on1++;
            if (busy2) on2++;
            if (rv2 && !got2) begin
                got2 = 1;
                obs2 = hilo2;
            end
            if (resp_valid) begin
                got = 1;
                obs = resp_hilo;
            end else begin
                @(posedge clk);
                #1;
                olat++;
            end
        end
        e = exp_q.pop_front();
        chk({tag, "/resp_seen"}, {63'b0, got}, 64'd1);
        chk(tag, obs, e);
        chk({tag, "/div2"}, obs2, e);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk({tag, "/hold_valid"}, {63'b0, resp_valid}, 64'd1);
            chk({tag, "/hold_hilo"}, resp_hilo, e);
        end
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack       = 1'b0;
        req_valid = 1'b0;
        req_op    = MD_NONE;
        @(negedge clk);
        chk({tag, "/idle"}, {62'b0, busy, resp_valid}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_op = MD_NONE;
        req_a = '0; req_b = '0; hilo_i = '0; flush = 1'b0; ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {61'b0, ready_o, resp_valid, busy}, 64'b100);
        chk("rst_hilo", resp_hilo, 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        req_valid = 1'b1;
        req_op    = MD_NONE;
        @(negedge clk);
        chk("md_none", {61'b0, ready_o, resp_valid, busy}, 64'b100);
        @(posedge clk);
        #1 req_valid = 1'b0;

        run_op("mult", MULT, 32'hffffffff, 32'd2, 64'd0, 0, lat, n1, n2);
        chk("mult_lat", 64'(lat), 64'd2);
        run_op("multu", MULTU, 32'hffffffff, 32'd2, 64'd0, 0, lat, n1, n2);
        chk("multu_lat", 64'(lat), 64'd2);
        run_op("msub", MSUB, 32'd1, 32'd1, 64'd0, 0, lat, n1, n2);
        run_op("madd", MADD, 32'hfffffff0, 32'd3, 64'h0000_0001_0000_0000,
               0, lat, n1, n2);
        run_op("maddu", MADDU, 32'h80000000, 32'h4, 64'hffff_ffff_ffff_ffff,
               0, lat, n1, n2);
        run_op("msubu", MSUBU, 32'h10, 32'h10, 64'h0, 0, lat, n1, n2);
        run_op("mtlo", MTLO, 32'h1234, 32'd0, 64'haaaa_0000_bbbb_0000,
               0, lat, n1, n2);
        chk("mtlo_lat", 64'(lat), 64'd0);
        run_op("mthi", MTHI, 32'hcafe, 32'd0, 64'haaaa_0000_bbbb_0000,
               0, lat, n1, n2);

        run_op("div_m7_2", DIV, 32'hfffffff9, 32'd2, 64'd0, 0, lat, n1, n2);
        chk("div_cycles_b1", 64'(n1), 64'd33);
        chk("div_cycles_b2", 64'(n2), 64'd17);
        run_op("div_ovf", DIV, 32'h80000000, 32'hffffffff, 64'd0,
               0, lat, n1, n2);
        run_op("divu_zero", DIVU, 32'd5, 32'd0, 64'd0, 0, lat, n1, n2);
        chk("divu_zero_lat", 64'(lat), 64'd1);
        run_op("divu", DIVU, 32'hfffffff9, 32'd2, 64'd0, 0, lat, n1, n2);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if (i == 3) rb = 32'hfffffffd;
            run_op("rnd", ops[$urandom_range(0, 7)], ra, rb,
                   {$urandom, $urandom}, 0, lat, n1, n2);
        end

        run_op("hold", MULTU, 32'h0001_0001, 32'h0003_0003, 64'd0,
               3, lat, n1, n2);

        // Abort a divide in its tenth DIV cycle.
        req_valid = 1'b1; req_op = DIV; req_a = 32'd100; req_b = 32'd3;
        k = 0;
        for (int i = 0; i < 60 && k < 10; i++) begin
            @(negedge clk);
            if (busy) k++;
            if (k < 10) begin
                @(posedge clk);
                #1;
            end
        end
        chk("flush_reach", 64'(k), 64'd10);
        flush = 1'b1;
        #1 chk("flush_cycle_rv", {62'b0, resp_valid, rv2}, 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; req_valid = 1'b0; req_op = MD_NONE;
        @(negedge clk);
        chk("flush_idle", {61'b0, busy, busy2, resp_valid}, 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid || rv2 || busy) seen++;
        end
        chk("flush_quiet", 64'(seen), 64'd0);
        @(posedge clk);
        #1;

        // Flush while DONE suppresses resp_valid the same cycle.
        req_valid = 1'b1; req_op = MULT; req_a = 32'd3; req_b = 32'd4;
        k = 0;
        for (int i = 0; i < 20 && k == 0; i++) begin
            @(negedge clk);
            if (resp_valid) k = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("fdone_reach", 64'(k), 64'd1);
        chk("fdone_hilo", resp_hilo, 64'd12);
        flush = 1'b1;
        #1 chk("fdone_rv", {63'b0, resp_valid}, 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; req_valid = 1'b0; req_op = MD_NONE;
        @(negedge clk);
        chk("fdone_idle", {62'b0, busy, resp_valid}, 64'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a multiply.
        req_valid = 1'b1; req_op = MULT; req_a = 32'd5; req_b = 32'd7;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rmul_busy", {63'b0, busy}, 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("rmul_ctl", {61'b0, ready_o, resp_valid, busy}, 64'b100);
        chk("rmul_hilo", resp_hilo, 64'd0);
        req_valid = 1'b0; req_op = MD_NONE;
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid || busy || rv2) seen++;
        end
        chk("rmul_quiet", 64'(seen), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set operand width W; HI/LO are each W bits.
REQ-002 Parameter MUL_LATENCY, default 2, range 1..4, SHALL set cycles from multiply start to result.
REQ-003 Parameter DIV_BITS, default 1, legal 1 or 2, SHALL set quotient bits retired per divide cycle; W SHALL be divisible by DIV_BITS.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  1  request present; fields held stable until ready_o=1.
REQ-008 req_op  in  muldiv_op_t  MD_NONE, MULT, MULTU, MADD, MADDU, MSUB, MSUBU, DIV, DIVU, MTHI, MTLO.
REQ-009 req_a, req_b  in  W each  rs and rt operands.
REQ-010 hilo_i  in  2W  current {HI,LO}, used for MADD*/MSUB*/MTHI/MTLO.
REQ-011 flush  in  1  abort the in-flight operation.
REQ-012 ack  in  1  downstream advanced this cycle; consumes the DONE result.
REQ-013 ready_o  out  1  high when the held request needs no further cycles.
REQ-014 resp_valid  out  1  resp_hilo is valid and is to be written to HI/LO this cycle.
REQ-015 resp_hilo  out  2W  result {HI,LO}.
REQ-016 busy  out  1  high in MUL or DIV state.

Function
REQ-017 FSM states SHALL be IDLE, MUL, DIV, DONE.
REQ-018 IDLE with req_valid=0 or req_op=MD_NONE: ready_o=1, resp_valid=0.
REQ-019 IDLE with MTHI/MTLO: same cycle ready_o=1, resp_valid=1; resp_hilo={req_a,hilo_i[W-1:0]} for MTHI, {hilo_i[2W-1:W],req_a} for MTLO; no state change.
REQ-020 IDLE with a multiply op: ready_o=0; capture operands and hilo_i; go MUL; cycle counter loads MUL_LATENCY-1.
REQ-021 MUL: counter decrements each cycle; counter=0 goes DONE. DONE is thus entered MUL_LATENCY cycles after the IDLE start cycle.
REQ-022 Product width is 2W. Signed variants sign-extend operands; unsigned variants zero-extend.
REQ-023 MADD*/MSUB* SHALL add the product to, or subtract it from, the captured hilo_i modulo 2^(2W).
REQ-024 IDLE with DIV/DIVU and req_b!=0: ready_o=0; go DIV. Restoring division on magnitudes retires DIV_BITS quotient bits per cycle for W/DIV_BITS cycles, then one sign-fix cycle, then DONE.
REQ-025 Signed quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-026 INT_MIN/-1 SHALL give LO=INT_MIN and HI=0.
REQ-027 DIV/DIVU with req_b=0 SHALL go directly to DONE with HI=req_a and LO=all ones, regardless of signedness.
REQ-028 DONE: ready_o=1, resp_valid=1, resp_hilo is the registered result. ack=1 goes IDLE; ack=0 holds DONE with the output stable.
REQ-029 flush=1 in any state SHALL force IDLE at the next edge and SHALL suppress resp_valid in that cycle; flush has priority over ack and over a new start.
REQ-030 A request arriving while not in IDLE is ignored. Operands are used only from the capture cycle.
REQ-031 busy=1 exactly in MUL and DIV.

Reset
REQ-032 While rst=0: state=IDLE, counters=0, result register=0. Outputs: ready_o=1, resp_valid=0, resp_hilo=0, busy=0.
REQ-033 Reset asserted mid-operation SHALL discard the operation; no resp_valid after release until a new request.

Structure
REQ-034 muldiv_op_t, the muldiv_state_t enum, and the MUL_LATENCY/DIV_BITS defaults SHALL live in the shared CPU package alongside oper_t.
REQ-035 The iterative divider datapath SHALL be one sub-module, div_iter: start, operands, signedness, done, quotient, remainder.
REQ-036 The multiplier SHALL be an MUL_LATENCY-deep registered pipeline inside muldiv_unit.

Verification
REQ-037 W=32, MULT a=0xFFFFFFFF, b=2, MUL_LATENCY=2 -> resp_valid two cycles after start, resp_hilo=0xFFFFFFFF_FFFFFFFE; MULTU same operands -> 0x00000001_FFFFFFFE.
REQ-038 DIV a=-7 (0xFFFFFFF9), b=2, DIV_BITS=1 -> DONE after 33 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; repeat with DIV_BITS=2 -> 17 cycles, same values.
REQ-039 DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU b=0, a=5 -> next cycle HI=5, LO=0xFFFFFFFF.
REQ-040 MSUB hilo_i=0, a=1, b=1 -> resp_hilo=0xFFFFFFFF_FFFFFFFF; MTLO a=0x1234, hilo_i=0xAAAA_0000_BBBB_0000 -> same cycle 0xAAAA0000_00001234.
REQ-041 Flush in DIV cycle 10 -> IDLE next cycle, no resp_valid; ack held 0 in DONE for 3 cycles -> output stable, then IDLE after ack.
REQ-042 Drive rst low during MUL -> all outputs at reset values immediately (asynchronously); after release, idle until a new request.
